// File: rtl/needbar_pkg.sv
// Shared types and constants for the need-bar frame sequencer.
package needbar_pkg;

  localparam int unsigned COLOR_W = 24;
  localparam int unsigned IDX_W   = 7;

  localparam logic [IDX_W-1:0] FIRST_PIX_DEF = 7'h40;
  localparam logic [IDX_W-1:0] LAST_PIX_DEF  = 7'h77;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SEND,
    ST_GAP
  } state_e;

  function automatic logic [7:0] dim_chan(input logic [7:0] c, input logic [1:0] d);
    return c >> d;
  endfunction

endpackage

// File: rtl/needbar_refresh_timer.sv
// Free-running refresh counter; emits a one-cycle tick at the top count.
// REFRESH_CYCLES = 0 removes the counter and ties the tick low.
module needbar_refresh_timer #(
  parameter int unsigned REFRESH_CYCLES = 2500000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  generate
    if (REFRESH_CYCLES == 0) begin : g_off
      assign tick = 1'b0;
    end else begin : g_cnt
      localparam int unsigned     CNT_W   = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
      localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(REFRESH_CYCLES - 1);

      logic [CNT_W-1:0] cnt_q, cnt_d;

      always_comb begin
        cnt_d = (cnt_q == CNT_TOP) ? '0 : cnt_q + 1'b1;
      end

      always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
      end

      assign tick = (cnt_q == CNT_TOP);
    end
  endgenerate

endmodule

// File: rtl/needbar_scanner.sv
// Need-bar frame sequencer: scans the pixel window, streams colours over
// valid/ready, then holds a latch gap. Optional macro NEEDBAR_DIM_EN adds `dim`.
module needbar_scanner
  import needbar_pkg::*;
#(
  parameter logic [IDX_W-1:0] FIRST_PIX      = FIRST_PIX_DEF,
  parameter logic [IDX_W-1:0] LAST_PIX       = LAST_PIX_DEF,
  parameter int unsigned      REFRESH_CYCLES = 2500000,
  parameter int unsigned      GAP_CYCLES     = 2600
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic [IDX_W-1:0]   pixel_idx,
  input  logic [COLOR_W-1:0] color_in,
  output logic [COLOR_W-1:0] pix_data,
  output logic               pix_valid,
  input  logic               pix_ready,
  output logic               frame_active,
  output logic               frame_done
`ifdef NEEDBAR_DIM_EN
  ,
  input  logic [1:0]         dim
`endif
);

  localparam int unsigned     GAP_W   = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_TOP = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [COLOR_W-1:0] pix_data_q, pix_data_d;
  logic               pix_valid_q, pix_valid_d;
  logic               frame_active_q, frame_active_d;
  logic               frame_done_q, frame_done_d;
  logic               pending_q, pending_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;

  logic               tick;
  logic               req;
  logic               hs;
  logic [COLOR_W-1:0] load_color;

  needbar_refresh_timer #(
    .REFRESH_CYCLES(REFRESH_CYCLES)
  ) u_refresh (
    .clk  (clk),
    .reset(reset),
    .tick (tick)
  );

  assign req = tick | start | pending_q;
  assign hs  = pix_valid_q & pix_ready;

`ifdef NEEDBAR_DIM_EN
  assign load_color = {dim_chan(color_in[23:16], dim),
                       dim_chan(color_in[15:8],  dim),
                       dim_chan(color_in[7:0],   dim)};
`else
  assign load_color = color_in;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      idx_q          <= FIRST_PIX;
      pix_data_q     <= '0;
      pix_valid_q    <= 1'b0;
      frame_active_q <= 1'b0;
      frame_done_q   <= 1'b0;
      pending_q      <= 1'b0;
      gap_cnt_q      <= '0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      pix_data_q     <= pix_data_d;
      pix_valid_q    <= pix_valid_d;
      frame_active_q <= frame_active_d;
      frame_done_q   <= frame_done_d;
      pending_q      <= pending_d;
      gap_cnt_q      <= gap_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (req) state_d = ST_LOAD;
      ST_LOAD: state_d = ST_SEND;
      ST_SEND: if (hs) state_d = (idx_q == LAST_PIX) ? ST_GAP : ST_LOAD;
      ST_GAP:  if (gap_cnt_q == GAP_TOP) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // The last-pixel compare precedes the increment, so LAST_PIX = 7'h7F never wraps.
  always_comb begin
    idx_d          = idx_q;
    pix_data_d     = pix_data_q;
    pix_valid_d    = pix_valid_q;
    frame_active_d = frame_active_q;
    frame_done_d   = 1'b0;
    pending_d      = pending_q | tick | start;
    gap_cnt_d      = gap_cnt_q;
    case (state_q)
      ST_IDLE: begin
        idx_d = FIRST_PIX;
        if (req) begin
          frame_active_d = 1'b1;
          pending_d      = 1'b0;
        end
      end
      ST_LOAD: begin
        pix_data_d  = load_color;
        pix_valid_d = 1'b1;
      end
      ST_SEND: begin
        if (hs) begin
          pix_valid_d = 1'b0;
          if (idx_q == LAST_PIX) gap_cnt_d = '0;
          else                   idx_d     = idx_q + 1'b1;
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == GAP_TOP) begin
          frame_done_d   = 1'b1;
          frame_active_d = 1'b0;
          idx_d          = FIRST_PIX;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign pixel_idx    = idx_q;
  assign pix_data     = pix_data_q;
  assign pix_valid    = pix_valid_q;
  assign frame_active = frame_active_q;
  assign frame_done   = frame_done_q;

endmodule
